// File: rtl/debouncer_nch.sv
`default_nettype none
// ============================================================================
//  Module      : debouncer_nch
//  Description : N-channel push-button / switch debouncer. Each channel has
//                a 2-FF synchroniser with optional inversion, a stability
//                filter, one-cycle rise/fall strobes, and long-press
//                detection with auto-repeat.
//  Revision    : 1.0 - initial release
// ============================================================================
module debouncer_nch #(
    parameter int              N_CH          = 4,
    parameter int              STABLE_CYCLES = 500000,
    parameter int              HOLD_CYCLES   = 50000000,
    parameter int              REPEAT_CYCLES = 10000000,
    parameter logic [N_CH-1:0] INVERT_MASK   = {N_CH{1'b0}}
) (
    input  logic            clk_50MHz,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] db_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] hold_out,
    output logic [N_CH-1:0] rpt_pulse
);

    // The hold counter serves both the hold-onset and repeat intervals, so
    // it is sized for whichever of the two is longer.
    localparam int C_SCNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam int C_HMAX   = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int C_HCNT_W = $clog2(C_HMAX) + 1;

    localparam logic [C_SCNT_W-1:0] C_STABLE_LAST = C_SCNT_W'(STABLE_CYCLES - 1);
    localparam logic [C_SCNT_W-1:0] C_SCNT_ONE    = C_SCNT_W'(1);
    localparam logic [C_HCNT_W-1:0] C_HOLD_LAST   = C_HCNT_W'(HOLD_CYCLES - 1);
    localparam logic [C_HCNT_W-1:0] C_RPT_LAST    =
        C_HCNT_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
    localparam logic [C_HCNT_W-1:0] C_HCNT_ONE    = C_HCNT_W'(1);
    localparam bit                  C_RPT_EN      = (REPEAT_CYCLES > 0);

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            logic                s1_q,   s1_d;
            logic                s2_q,   s2_d;
            logic                db_q,   db_d;
            logic                rise_q, rise_d;
            logic                fall_q, fall_d;
            logic                hold_q, hold_d;
            logic                rpt_q,  rpt_d;
            logic [C_SCNT_W-1:0] cnt_q,  cnt_d;
            logic [C_HCNT_W-1:0] hcnt_q, hcnt_d;

            // Synchroniser: inversion is applied before the first flop so
            // every later stage sees an active-high level.
            always_comb begin
                s1_d = btn_in[i] ^ INVERT_MASK[i];
                s2_d = s1_q;
            end

            // Stability filter: a new level must mismatch the current
            // debounced level for STABLE_CYCLES consecutive cycles; any
            // return to the old level restarts qualification.
            always_comb begin
                db_d  = db_q;
                cnt_d = cnt_q;
                if (s2_q == db_q) begin
                    cnt_d = '0;
                end else if (cnt_q == C_STABLE_LAST) begin
                    db_d  = s2_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + C_SCNT_ONE;
                end
            end

            // Edge strobes are registered so they line up with db_out.
            always_comb begin
                rise_d = ~db_q &  db_d;
                fall_d =  db_q & ~db_d;
            end

            // Hold / auto-repeat. Cleared while released and on the falling
            // edge itself, so a repeat can never coincide with a release.
            always_comb begin
                hold_d = hold_q;
                hcnt_d = hcnt_q;
                rpt_d  = 1'b0;
                if (!db_q || !db_d) begin
                    hold_d = 1'b0;
                    hcnt_d = '0;
                end else if (!hold_q) begin
                    if (hcnt_q == C_HOLD_LAST) begin
                        hold_d = 1'b1;
                        rpt_d  = 1'b1;
                        hcnt_d = '0;
                    end else begin
                        hcnt_d = hcnt_q + C_HCNT_ONE;
                    end
                end else if (C_RPT_EN) begin
                    if (hcnt_q == C_RPT_LAST) begin
                        rpt_d  = 1'b1;
                        hcnt_d = '0;
                    end else begin
                        hcnt_d = hcnt_q + C_HCNT_ONE;
                    end
                end
            end

            // Channel state register with asynchronous active-low clear.
            always_ff @(posedge clk_50MHz or negedge reset) begin
                if (!reset) begin
                    s1_q   <= 1'b0;
                    s2_q   <= 1'b0;
                    db_q   <= 1'b0;
                    cnt_q  <= '0;
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                    hold_q <= 1'b0;
                    rpt_q  <= 1'b0;
                    hcnt_q <= '0;
                end else begin
                    s1_q   <= s1_d;
                    s2_q   <= s2_d;
                    db_q   <= db_d;
                    cnt_q  <= cnt_d;
                    rise_q <= rise_d;
                    fall_q <= fall_d;
                    hold_q <= hold_d;
                    rpt_q  <= rpt_d;
                    hcnt_q <= hcnt_d;
                end
            end

            assign db_out[i]     = db_q;
            assign rise_pulse[i] = rise_q;
            assign fall_pulse[i] = fall_q;
            assign hold_out[i]   = hold_q;
            assign rpt_pulse[i]  = rpt_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debouncer_nch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debouncer_nch
//  Description : Directed self-checking bench for debouncer_nch with
//                N_CH=4, STABLE=4, HOLD=20, REPEAT=6, INVERT_MASK=4'b0010.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debouncer_nch;

    logic       clk;
    logic       reset;
    logic [3:0] btn;
    logic [3:0] db_out, rise_pulse, fall_pulse, hold_out, rpt_pulse;
    logic [19:0] obs;

    int checks;
    int errors;

    debouncer_nch #(
        .N_CH          (4),
        .STABLE_CYCLES (4),
        .HOLD_CYCLES   (20),
        .REPEAT_CYCLES (6),
        .INVERT_MASK   (4'b0010)
    ) dut (
        .clk_50MHz  (clk),
        .reset      (reset),
        .btn_in     (btn),
        .db_out     (db_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .hold_out   (hold_out),
        .rpt_pulse  (rpt_pulse)
    );

    assign obs = {db_out, rise_pulse, fall_pulse, hold_out, rpt_pulse};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] ex(input logic [3:0] d, input logic [3:0] r,
                                       input logic [3:0] f, input logic [3:0] h,
                                       input logic [3:0] p);
        return {d, r, f, h, p};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [19:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (db/rise/fall/hold/rpt)", tag, obs, expv);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        btn    = 4'($urandom);

        // Reset held with random inputs
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("reset_hold", ex(4'b0, 4'b0, 4'b0, 4'b0, 4'b0));
            btn = 4'($urandom);
        end

        // Release with ch1 inverted-idle: nothing may change
        btn   = 4'b0010;
        reset = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            chk("idle", ex(4'b0, 4'b0, 4'b0, 4'b0, 4'b0));
        end

        // Clean press / release on ch0
        btn = 4'b0011;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("press0_wait", ex(4'b0, 4'b0, 4'b0, 4'b0, 4'b0));
        end
        tick(); chk("press0_rise", ex(4'b0001, 4'b0001, 4'b0, 4'b0, 4'b0));
        btn = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("rel0_wait", ex(4'b0001, 4'b0, 4'b0, 4'b0, 4'b0));
        end
        tick(); chk("rel0_fall", ex(4'b0, 4'b0, 4'b0001, 4'b0, 4'b0));
        tick(); chk("rel0_after", ex(4'b0, 4'b0, 4'b0, 4'b0, 4'b0));

        // Glitch rejection on ch2: 3 high / 1 low, ten times
        for (int rep = 0; rep < 10; rep++) begin
            for (int c = 0; c < 4; c++) begin
                btn = (c < 3) ? 4'b0110 : 4'b0010;
                tick();
                chk("glitch2", ex(4'b0, 4'b0, 4'b0, 4'b0, 4'b0));
            end
        end
        btn = 4'b0110;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stable2_wait", ex(4'b0, 4'b0, 4'b0, 4'b0, 4'b0));
        end
        tick(); chk("stable2_rise", ex(4'b0100, 4'b0100, 4'b0, 4'b0, 4'b0));
        btn = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("rel2_wait", ex(4'b0100, 4'b0, 4'b0, 4'b0, 4'b0));
        end
        tick(); chk("rel2_fall", ex(4'b0, 4'b0, 4'b0100, 4'b0, 4'b0));

        // Long press on ch3; release so the fall lands on a repeat slot
        btn = 4'b1010;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("press3_wait", ex(4'b0, 4'b0, 4'b0, 4'b0, 4'b0));
        end
        tick(); chk("press3_rise", ex(4'b1000, 4'b1000, 4'b0, 4'b0, 4'b0));
        for (int k = 1; k <= 67; k++) begin
            logic       h;
            logic       p;
            h = (k >= 20);
            p = (k >= 20) && (((k - 20) % 6) == 0);
            tick();
            chk("hold3", ex(4'b1000, 4'b0, 4'b0, {h, 3'b0}, {p, 3'b0}));
            if (k == 62) btn = 4'b0010;
        end
        tick(); chk("hold3_fall", ex(4'b0, 4'b0, 4'b1000, 4'b0, 4'b0));
        tick(); chk("hold3_after", ex(4'b0, 4'b0, 4'b0, 4'b0, 4'b0));

        // Simultaneous: inverted ch1 pressed (1->0) with ch0 pressed
        btn = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("simul_wait", ex(4'b0, 4'b0, 4'b0, 4'b0, 4'b0));
        end
        tick(); chk("simul_rise", ex(4'b0011, 4'b0011, 4'b0, 4'b0, 4'b0));
        btn = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("simul_rel_wait", ex(4'b0011, 4'b0, 4'b0, 4'b0, 4'b0));
        end
        tick(); chk("simul_fall", ex(4'b0, 4'b0, 4'b0011, 4'b0, 4'b0));

        // Reset mid-hold on ch3
        btn = 4'b1010;
        for (int c = 0; c < 6; c++) tick();
        chk("mid_rise", ex(4'b1000, 4'b1000, 4'b0, 4'b0, 4'b0));
        for (int c = 0; c < 20; c++) tick();
        chk("mid_onset", ex(4'b1000, 4'b0, 4'b0, 4'b1000, 4'b1000));
        #2;
        reset = 1'b0;
        #1;
        chk("mid_async_clear", ex(4'b0, 4'b0, 4'b0, 4'b0, 4'b0));
        tick();
        chk("mid_in_reset", ex(4'b0, 4'b0, 4'b0, 4'b0, 4'b0));
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("requal_wait", ex(4'b0, 4'b0, 4'b0, 4'b0, 4'b0));
        end
        tick(); chk("requal_rise", ex(4'b1000, 4'b1000, 4'b0, 4'b0, 4'b0));
        for (int c = 0; c < 19; c++) begin
            tick();
            chk("requal_hold_wait", ex(4'b1000, 4'b0, 4'b0, 4'b0, 4'b0));
        end
        tick(); chk("requal_onset", ex(4'b1000, 4'b0, 4'b0, 4'b1000, 4'b1000));

        btn = 4'b0010;
        for (int c = 0; c < 10; c++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
